// File: rtl/bcd_serializer_if.sv
// bcd_serializer_if
//   Handshake bundle for the BCD digit serializer.
//   Word side  : in_valid/in_ready handshake, in_bcd packed word, in_skip_lz option.
//   Digit side : out_valid/out_ready stream, out_digit, out_last, out_index,
//                err_digit, and the done pulse that follows a completed word.
//   master : the environment (offers words, sinks digits).
//   slave  : the serializer itself.
interface bcd_serializer_if #(
  parameter int NUM_DIGITS = 300,
  parameter int CW         = $clog2(NUM_DIGITS)
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [4*NUM_DIGITS-1:0] in_bcd;
  logic                    in_skip_lz;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_digit;
  logic                    out_last;
  logic [CW-1:0]           out_index;
  logic                    err_digit;
  logic                    done;

  modport master (
    output in_valid, in_bcd, in_skip_lz, out_ready,
    input  in_ready, out_valid, out_digit, out_last, out_index, err_digit, done
  );

  modport slave (
    input  in_valid, in_bcd, in_skip_lz, out_ready,
    output in_ready, out_valid, out_digit, out_last, out_index, err_digit, done
  );
endinterface

// File: rtl/bcd_serializer.sv
// bcd_serializer
//   Takes one packed word of NUM_DIGITS BCD digits and streams it out one
//   digit per beat, most-significant digit first. Optionally drops leading
//   zero digits (never the final digit), and replaces raw digits above 9 with
//   0 while raising err_digit for that beat.
// Ports
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : bcd_serializer_if.slave (word handshake in, digit stream out)
// All outputs are decoded from registered state only.
module bcd_serializer #(
  parameter int NUM_DIGITS = 300,
  parameter int CW         = $clog2(NUM_DIGITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_serializer_if.slave      bus
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  logic [3:0]      raw_top;
  logic [3:0]      raw_next;

  // Digits above 9 are not representable on the link; they go out as 0.
  function automatic logic [3:0] sanitize_digit(input logic [3:0] raw);
    return (raw > 4'd9) ? 4'd0 : raw;
  endfunction

  assign raw_top  = shift_q[W-1 -: 4];
  assign raw_next = shift_q[W-5 -: 4];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.in_bcd;
          idx_d   = CW'(NUM_DIGITS - 1);
          if (bus.in_skip_lz && (bus.in_bcd[W-1 -: 4] == 4'd0))
            state_d = SKIP;
          else
            state_d = SEND;
        end
      end
      SKIP: begin
        // Drop the zero on top; stop once a nonzero digit is next or only
        // the final digit remains, so an all-zero word still emits one beat.
        shift_d = {shift_q[W-5:0], 4'h0};
        idx_d   = idx_q - CW'(1);
        if ((raw_next != 4'd0) || (idx_q == CW'(1)))
          state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          shift_d = {shift_q[W-5:0], 4'h0};
          if (idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Output decode
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_digit = sanitize_digit(raw_top);
  assign bus.err_digit = (state_q == SEND) && (raw_top > 4'd9);
  assign bus.out_last  = (state_q == SEND) && (idx_q == '0);
  assign bus.out_index = idx_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bcd_serializer.sv
// tb_bcd_serializer
//   Directed bench for bcd_serializer: a 4-digit instance driven with
//   hand-computed vectors and a 300-digit instance checked against a small
//   digit model.
module tb_bcd_serializer;

  localparam int N4  = 4;
  localparam int N2  = 300;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_serializer_if #(.NUM_DIGITS(N4)) a ();
  bcd_serializer_if #(.NUM_DIGITS(N2)) b ();

  bcd_serializer #(.NUM_DIGITS(N4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  bcd_serializer #(.NUM_DIGITS(N2)) dut300 (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a word to the 4-digit instance at the current (negedge) cycle.
  task automatic start4(input logic [15:0] w, input logic skip);
    a.in_valid   = 1'b1;
    a.in_bcd     = w;
    a.in_skip_lz = skip;
  endtask

  // Called at the negedge of the accept cycle T. rdy bit c-1 is out_ready in
  // cycle T+c. ed holds expected digits, beat b at nibble nb-1-b; ee the
  // matching err flags. Returns at the negedge of the done cycle.
  task automatic run4(input string nm, input logic [15:0] rdy, input logic [15:0] ed,
                      input logic [3:0] ee, input int nb, input int first,
                      input bit hold, input logic [15:0] nxt);
    int bt  = 0;
    int cyc = 0;
    int k;
    chk({nm, ".acc_rdy"}, a.in_ready, 1);
    while (bt < nb && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hold) a.in_bcd = nxt;
      else      a.in_valid = 1'b0;
      a.out_ready = (cyc <= 16) ? rdy[cyc-1] : 1'b1;
      chk({nm, ".busy_rdy"}, a.in_ready, 0);
      chk({nm, ".busy_done"}, a.done, 0);
      if (cyc < first) begin
        chk({nm, ".pre_vld"}, a.out_valid, 0);
      end else begin
        k = nb - 1 - bt;
        chk({nm, ".vld"},   a.out_valid, 1);
        chk({nm, ".digit"}, a.out_digit, ed[4*k +: 4]);
        chk({nm, ".index"}, a.out_index, k);
        chk({nm, ".last"},  a.out_last, (k == 0));
        chk({nm, ".err"},   a.err_digit, ee[k]);
        if (a.out_ready) bt++;
      end
    end
    chk({nm, ".beats"}, bt, nb);
    @(negedge clk);
    if (!hold) a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    chk({nm, ".done"},     a.done, 1);
    chk({nm, ".done_rdy"}, a.in_ready, 1);
    chk({nm, ".done_vld"}, a.out_valid, 0);
  endtask

  // 300-digit word against a digit model, random backpressure. When
  // stop_after >= 0 it returns after that many beats, leaving the word active.
  task automatic run300(input string nm, input logic [4*N2-1:0] w, input bit skip,
                        input int stop_after);
    int z     = 0;
    int k;
    int beats = 0;
    int cyc   = 0;
    logic [3:0] raw;
    if (skip) while (z < N2 - 1 && w[4*(N2-1-z) +: 4] == 4'd0) z++;
    k = N2 - 1 - z;
    b.in_valid   = 1'b1;
    b.in_bcd     = w;
    b.in_skip_lz = skip;
    chk({nm, ".acc_rdy"}, b.in_ready, 1);
    while (k >= 0 && beats != stop_after && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      b.in_valid  = 1'b0;
      b.out_ready = ($urandom_range(0, 3) != 0);
      if (cyc < 1 + z) begin
        chk({nm, ".skip_vld"}, b.out_valid, 0);
      end else begin
        raw = w[4*k +: 4];
        chk({nm, ".vld"},   b.out_valid, 1);
        chk({nm, ".digit"}, b.out_digit, (raw > 4'd9) ? 4'd0 : raw);
        chk({nm, ".index"}, b.out_index, k);
        chk({nm, ".last"},  b.out_last, (k == 0));
        chk({nm, ".err"},   b.err_digit, (raw > 4'd9));
        if (b.out_ready) begin
          k--;
          beats++;
        end
      end
    end
    if (stop_after >= 0) begin
      chk({nm, ".part_beats"}, beats, stop_after);
    end else begin
      chk({nm, ".beats"}, beats, N2 - z);
      @(negedge clk);
      b.out_ready = 1'b1;
      chk({nm, ".done"},     b.done, 1);
      chk({nm, ".done_rdy"}, b.in_ready, 1);
    end
  endtask

  function automatic logic [4*N2-1:0] rand_word(input int lead_zeros);
    logic [4*N2-1:0] w;
    for (int i = 0; i < N2; i++) begin
      if (i >= N2 - lead_zeros)          w[4*i +: 4] = 4'd0;
      else if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                w[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    a.in_valid   = 1'b0;
    a.in_bcd     = '0;
    a.in_skip_lz = 1'b0;
    a.out_ready  = 1'b1;
    b.in_valid   = 1'b0;
    b.in_bcd     = '0;
    b.in_skip_lz = 1'b0;
    b.out_ready  = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst.in_ready",  a.in_ready, 1);
    chk("rst.out_valid", a.out_valid, 0);
    chk("rst.out_last",  a.out_last, 0);
    chk("rst.out_digit", a.out_digit, 0);
    chk("rst.out_index", a.out_index, 0);
    chk("rst.err_digit", a.err_digit, 0);
    chk("rst.done",      a.done, 0);
    reset = 1'b0;
    @(negedge clk);

    start4(16'h1234, 1'b0);
    run4("basic", 16'hFFFF, 16'h1234, 4'b0000, 4, 1, 1'b0, 16'h0);

    start4(16'h9081, 1'b0);
    run4("bp", 16'hFFE9, 16'h9081, 4'b0000, 4, 1, 1'b0, 16'h0);

    start4(16'h0056, 1'b1);
    run4("lz", 16'hFFFF, 16'h0056, 4'b0000, 2, 3, 1'b0, 16'h0);

    start4(16'h0000, 1'b1);
    run4("allzero", 16'hFFFF, 16'h0000, 4'b0000, 1, 4, 1'b0, 16'h0);

    start4(16'h0056, 1'b0);
    run4("nolz", 16'hFFFF, 16'h0056, 4'b0000, 4, 1, 1'b0, 16'h0);

    start4(16'h3A7F, 1'b1);
    run4("inv", 16'hFFFF, 16'h3070, 4'b0101, 4, 1, 1'b0, 16'h0);

    start4(16'hB000, 1'b1);
    run4("invlead", 16'hFFFF, 16'h0000, 4'b1000, 4, 1, 1'b0, 16'h0);

    start4(16'h1111, 1'b0);
    run4("b2b1", 16'hFFFF, 16'h1111, 4'b0000, 4, 1, 1'b1, 16'h2222);
    run4("b2b2", 16'hFFFF, 16'h2222, 4'b0000, 4, 1, 1'b0, 16'h0);

    // Reset in the middle of 16'h5678 after two beats.
    start4(16'h5678, 1'b0);
    @(negedge clk);
    a.in_valid = 1'b0;
    chk("mid.b1_digit", a.out_digit, 5);
    chk("mid.b1_index", a.out_index, 3);
    @(negedge clk);
    chk("mid.b2_digit", a.out_digit, 6);
    chk("mid.b2_index", a.out_index, 2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid.rst_valid", a.out_valid, 0);
    chk("mid.rst_ready", a.in_ready, 1);
    chk("mid.rst_digit", a.out_digit, 0);
    chk("mid.rst_index", a.out_index, 0);
    chk("mid.rst_last",  a.out_last, 0);
    chk("mid.rst_err",   a.err_digit, 0);
    chk("mid.rst_done",  a.done, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid.hold_done", a.done, 0);
    @(negedge clk);
    chk("mid.post_done",  a.done, 0);
    chk("mid.post_valid", a.out_valid, 0);
    start4(16'h4321, 1'b0);
    run4("after_rst", 16'hFFFF, 16'h4321, 4'b0000, 4, 1, 1'b0, 16'h0);

    // 300-digit instance.
    run300("w300a", rand_word(5), 1'b1, 100);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("w300.rst_valid", b.out_valid, 0);
    chk("w300.rst_ready", b.in_ready, 1);
    chk("w300.rst_done",  b.done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("w300.post_done", b.done, 0);
    run300("w300b", rand_word(0), 1'b0, -1);
    run300("w300c", rand_word(7), 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
